// File: rtl/dm_store_buffer_pkg.sv
// Shared opcodes, entry layout and store-kind decode for the data-memory store buffer.
package dm_store_buffer_pkg;

  localparam logic [5:0] LW_OP  = 6'b100011;
  localparam logic [5:0] LH_OP  = 6'b100001;
  localparam logic [5:0] LHU_OP = 6'b100101;
  localparam logic [5:0] LB_OP  = 6'b100000;
  localparam logic [5:0] LBU_OP = 6'b100100;
  localparam logic [5:0] SW_OP  = 6'b101011;
  localparam logic [5:0] SH_OP  = 6'b101001;
  localparam logic [5:0] SB_OP  = 6'b101000;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_WORD = 2'd1,
    ST_HALF = 2'd2,
    ST_BYTE = 2'd3
  } st_kind_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] data;
  } sb_entry_t;

  function automatic st_kind_t st_kind(input logic [5:0] op);
    case (op)
      SW_OP:   return ST_WORD;
      SH_OP:   return ST_HALF;
      SB_OP:   return ST_BYTE;
      default: return ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dm_store_buffer_if.sv
// Memory-side write port of the store buffer: head entry plus req/ack handshake.
interface dm_store_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  modport master (output mem_req, output mem_addr, output mem_wdata, output mem_be,
                  input  mem_ack);
  modport slave  (input  mem_req, input  mem_addr, input  mem_wdata, input  mem_be,
                  output mem_ack);
endinterface

// File: rtl/dm_store_buffer_store_align.sv
// Combinational store decode: byte enables, lane-replicated data and AdES detection.
module dm_store_buffer_store_align
  import dm_store_buffer_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wd_i,
  input  logic        st_valid_i,
  output logic        is_st_o,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] data_o
);

  st_kind_t kind;
  logic     bad_align;

  always_comb begin
    kind      = st_kind(opcode_i);
    be_o      = 4'b0000;
    data_o    = wd_i;
    bad_align = 1'b0;
    case (kind)
      ST_WORD: begin
        be_o      = 4'b1111;
        bad_align = (addr_lo_i != 2'b00);
      end
      ST_HALF: begin
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        data_o    = {2{wd_i[15:0]}};
        bad_align = addr_lo_i[0];
      end
      ST_BYTE: begin
        be_o   = 4'b0001 << addr_lo_i;
        data_o = {4{wd_i[7:0]}};
      end
      default: ;
    endcase
    is_st_o    = st_valid_i && (kind != ST_NONE);
    misalign_o = is_st_o && bad_align;
  end

endmodule

// File: rtl/dm_store_buffer.sv
// M-stage store FIFO draining to data memory over req/ack; stalls on full or on a
// load to a word still pending. Accepted store is presented the cycle after enqueue.
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] MemAddr,
  input  logic [31:0] WD_in,
  input  logic        st_valid,
  input  logic        ld_check,
  output logic        stall,
  output logic        misalign,
  output logic        empty,
  dm_store_buffer_if.master mem
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic             is_st;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic [25:0]      unused_ir;

  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        new_entry;

  logic full, enq, pop, hit, full_stall, ld_stall;

  assign unused_ir = IR_M[25:0];

  dm_store_buffer_store_align u_store_align (
    .opcode_i   (IR_M[31:26]),
    .addr_lo_i  (MemAddr[1:0]),
    .wd_i       (WD_in),
    .st_valid_i (st_valid),
    .is_st_o    (is_st),
    .misalign_o (misalign),
    .be_o       (st_be),
    .data_o     (st_data)
  );

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign pop       = !empty && mem.mem_ack;
  // No same-cycle bypass: a pop does not free a slot for the store seen this cycle.
  assign enq        = is_st && !misalign && !full;
  assign full_stall = is_st && !misalign && full;
  assign new_entry  = '{waddr: MemAddr[31:2], be: st_be, data: st_data};

  // Hazard uses the pre-edge valid bits, so an entry being popped still stalls a load.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].waddr == MemAddr[31:2])) hit = 1'b1;
    end
  end

  assign ld_stall = ld_check && hit;
  assign stall    = full_stall || ld_stall;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (enq) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (enq && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!enq && pop) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      if (enq) entry_q[wr_ptr_q] <= new_entry;
    end
  end

  assign mem.mem_req   = !empty;
  assign mem.mem_addr  = {entry_q[rd_ptr_q].waddr, 2'b00};
  assign mem.mem_be    = entry_q[rd_ptr_q].be;
  assign mem.mem_wdata = entry_q[rd_ptr_q].data;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer with a queue-based reference model checked every cycle.
module tb_dm_store_buffer;

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam int         CAP    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_M, MemAddr, WD_in;
  logic        st_valid, ld_check;
  logic        stall, misalign, empty;
  logic        model_on = 1'b0;
  int          errors = 0;
  int          checks = 0;

  dm_store_buffer_if mif ();

  dm_store_buffer #(.DEPTH(2), .PTR_W(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .IR_M     (IR_M),
    .MemAddr  (MemAddr),
    .WD_in    (WD_in),
    .st_valid (st_valid),
    .ld_check (ld_check),
    .stall    (stall),
    .misalign (misalign),
    .empty    (empty),
    .mem      (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the store rules, using plain arithmetic.
  function automatic void decode(input logic [31:0] ir, input logic [31:0] a,
                                 input logic [31:0] wd, input logic v,
                                 output logic st, output logic mis,
                                 output logic [3:0] be, output logic [31:0] data);
    logic [5:0] op;
    op = ir[31:26];
    st = 1'b0; mis = 1'b0; be = 4'h0; data = 32'h0;
    if (v && op == OP_SW) begin
      st = 1'b1; be = 4'hF; data = wd; mis = (a % 4) != 0;
    end else if (v && op == OP_SH) begin
      st = 1'b1; be = ((a % 4) >= 2) ? 4'hC : 4'h3;
      data = wd[15:0] * 32'h0001_0001; mis = (a % 2) != 0;
    end else if (v && op == OP_SB) begin
      st = 1'b1; be = 4'(1 << (a % 4)); data = wd[7:0] * 32'h0101_0101;
    end
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      logic st, mis, hit;
      logic [3:0] be;
      logic [31:0] data;
      decode(IR_M, MemAddr, WD_in, st_valid, st, mis, be, data);
      hit = 1'b0;
      foreach (q[i]) if ((q[i].addr >> 2) == (MemAddr >> 2)) hit = 1'b1;
      chk("model_misalign", 32'(misalign), 32'(st && mis));
      chk("model_stall", 32'(stall), 32'((st && !mis && q.size() == CAP) || (ld_check && hit)));
      chk("model_empty", 32'(empty), 32'(q.size() == 0));
      chk("model_req", 32'(mif.mem_req), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("model_addr", mif.mem_addr, q[0].addr);
        chk("model_be", 32'(mif.mem_be), 32'(q[0].be));
        chk("model_wdata", mif.mem_wdata, q[0].data);
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
    end else if (model_on) begin
      logic st, mis, pop, push;
      logic [3:0] be;
      logic [31:0] data;
      exp_t e;
      decode(IR_M, MemAddr, WD_in, st_valid, st, mis, be, data);
      pop  = (q.size() != 0) && mif.mem_ack;
      push = st && !mis && (q.size() < CAP);
      e.addr = MemAddr & 32'hFFFF_FFFC; e.be = be; e.data = data;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (q.size() > CAP) begin
        errors++;
        $display("FAIL model_overflow: got %0d entries expected at most %0d", q.size(), CAP);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
    IR_M = {op, 26'h0}; MemAddr = a; WD_in = d; st_valid = 1'b1; ld_check = 1'b0;
  endtask

  task automatic set_ld(input logic [31:0] a);
    IR_M = {OP_LBU, 26'h0}; MemAddr = a; WD_in = 32'h0; st_valid = 1'b1; ld_check = 1'b1;
  endtask

  task automatic set_idle();
    IR_M = 32'h0; MemAddr = 32'h0; WD_in = 32'h0; st_valid = 1'b0; ld_check = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    mif.mem_ack = 1'b0;
    set_idle();
    step();
    model_on = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_addr", mif.mem_addr, 32'h0);
    chk("rst_be", 32'(mif.mem_be), 32'h0);
    chk("rst_wdata", mif.mem_wdata, 32'h0);

    // sb to a high byte lane, memory always ready
    mif.mem_ack = 1'b1;
    step(); set_st(OP_SB, 32'h0000_1003, 32'h1234_56AB);
    #1 chk("sb_misalign", 32'(misalign), 32'd0);
    step(); set_idle();
    #1;
    chk("sb_req", 32'(mif.mem_req), 32'd1);
    chk("sb_addr", mif.mem_addr, 32'h0000_1000);
    chk("sb_be", 32'(mif.mem_be), 32'h8);
    chk("sb_wdata", mif.mem_wdata, 32'hABAB_ABAB);
    step();
    #1 chk("sb_empty", 32'(empty), 32'd1);
    mif.mem_ack = 1'b0;

    // halfword stores, aligned then misaligned
    step(); set_st(OP_SH, 32'h0000_2002, 32'hFFFF_8001);
    step(); set_st(OP_SH, 32'h0000_2001, 32'h0000_5555);
    #1;
    chk("sh_be", 32'(mif.mem_be), 32'hC);
    chk("sh_wdata", mif.mem_wdata, 32'h8001_8001);
    chk("sh_misalign", 32'(misalign), 32'd1);
    chk("sh_mis_stall", 32'(stall), 32'd0);
    step(); set_st(OP_SW, 32'h0000_3002, 32'h1111_2222);
    #1 chk("sw_misalign", 32'(misalign), 32'd1);
    step(); set_idle();
    #1 chk("sh_one_entry", 32'(empty), 32'd0);
    mif.mem_ack = 1'b1;
    step(); mif.mem_ack = 1'b0;
    #1 chk("sh_drained", 32'(empty), 32'd1);

    // fill to capacity, full stall with no same-cycle bypass
    step(); set_st(OP_SW, 32'h10, 32'hA0);
    step(); set_st(OP_SW, 32'h14, 32'hA1);
    step(); set_st(OP_SW, 32'h18, 32'hA2);
    #1 chk("full_stall", 32'(stall), 32'd1);
    step();
    #1 chk("full_hold_stall", 32'(stall), 32'd1);
    chk("full_head", mif.mem_addr, 32'h10);
    mif.mem_ack = 1'b1;
    #1 chk("full_ack_stall", 32'(stall), 32'd1);
    step(); mif.mem_ack = 1'b0;
    #1 chk("full_accept", 32'(stall), 32'd0);
    chk("full_head2", mif.mem_addr, 32'h14);
    step(); set_idle();
    #1 chk("full_head2b", mif.mem_addr, 32'h14);
    mif.mem_ack = 1'b1;
    step();
    #1 chk("full_head3", mif.mem_addr, 32'h18);
    step();
    #1 chk("full_drained", 32'(empty), 32'd1);
    mif.mem_ack = 1'b0;

    // load hazard against a pending word
    step(); set_st(OP_SW, 32'h40, 32'h55);
    step(); set_ld(32'h44);
    #1 chk("ld_other_word", 32'(stall), 32'd0);
    set_ld(32'h43);
    #1 chk("ld_hazard", 32'(stall), 32'd1);
    step();
    #1 chk("ld_hazard_hold", 32'(stall), 32'd1);
    mif.mem_ack = 1'b1;
    #1 chk("ld_hazard_ack", 32'(stall), 32'd1);
    step(); mif.mem_ack = 1'b0;
    #1 chk("ld_released", 32'(stall), 32'd0);
    set_idle();

    // back-to-back stores with memory always ready
    mif.mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); set_st(OP_SW, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      if (i > 0) begin
        #1;
        chk("b2b_req", 32'(mif.mem_req), 32'd1);
        chk("b2b_addr", mif.mem_addr, 32'h100 + 32'(4 * (i - 1)));
        chk("b2b_stall", 32'(stall), 32'd0);
      end
    end
    step(); set_idle();
    #1 chk("b2b_last", mif.mem_addr, 32'h114);
    step();
    #1 chk("b2b_empty", 32'(empty), 32'd1);
    mif.mem_ack = 1'b0;

    // reset with two entries pending
    step(); set_st(OP_SW, 32'h200, 32'hDEAD_0001);
    step(); set_st(OP_SW, 32'h204, 32'hDEAD_0002);
    step(); set_idle();
    #1 chk("pre_rst_pending", 32'(empty), 32'd0);
    reset = 1'b1;
    step(); reset = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mif.mem_req), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_addr", mif.mem_addr, 32'h0);
    set_ld(32'h200);
    #1 chk("mid_rst_stall", 32'(stall), 32'd0);
    mif.mem_ack = 1'b1;
    step(); mif.mem_ack = 1'b0; set_idle();
    #1;
    chk("late_ack_req", 32'(mif.mem_req), 32'd0);
    chk("late_ack_empty", 32'(empty), 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_store_buffer.md
Name: dm_store_buffer

Overview:
- Store-side counterpart to the load data extender, sitting between the M stage and data memory.
- Decodes sw/sh/sb from IR_M and produces the byte-enable mask and lane-replicated write data.
- Queues accepted stores in a small FIFO and drains them to memory over a req/ack handshake.
- Stalls the pipeline when the FIFO is full, or when a load targets a word still pending in the FIFO.

Parameters:
- DEPTH, 2, number of store entries held; must be a power of two, 2 or greater.
- PTR_W, 1, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- IR_M  input  32  M-stage instruction; the opcode is IR_M[31:26].
- MemAddr  input  32  M-stage byte address from the ALU.
- WD_in  input  32  M-stage store data (forwarded rt value).
- st_valid  input  1  M-stage instruction is valid (not a bubble).
- ld_check  input  1  M-stage instruction is a load (lw/lh/lhu/lb/lbu).
- stall  output  1  freezes the F, D, E and M stages this cycle.
- misalign  output  1  store address exception (AdES), combinational.
- mem_req  output  1  head entry presented to memory.
- mem_addr  output  32  word-aligned address {addr[31:2], 2'b00}.
- mem_wdata  output  32  lane-aligned write data.
- mem_be  output  4  byte enables; bit i enables byte lane i.
- mem_ack  input  1  memory accepted the head entry this cycle.
- empty  output  1  FIFO holds no entries.

Behaviour:
Decode (combinational):
- is_st = st_valid and opcode in {SW 101011, SH 101001, SB 101000}.
- SW: be = 1111, data = WD_in.
- SH: be = 0011 when MemAddr[1] = 0, else 1100; data = {WD_in[15:0], WD_in[15:0]}.
- SB: be = 0001 << MemAddr[1:0]; data = {4{WD_in[7:0]}}.
- misalign = is_st and ((SW and MemAddr[1:0] != 0) or (SH and MemAddr[0] = 1)).
- A misaligned store is never enqueued and never causes a stall.

Enqueue:
- enq = is_st and not misalign and not full.
- On enq, the entry {MemAddr[31:2], be, data} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Full stall: full_stall = is_st and not misalign and full. A full FIFO stalls even if mem_ack pops an entry in the same cycle (no same-cycle bypass); the store is accepted on the next cycle.

Drain:
- mem_req = (count != 0). mem_addr, mem_be and mem_wdata come from the head entry registers.
- Outputs stay stable while mem_req is high and mem_ack is low.
- mem_ack is ignored when mem_req is low.
- On mem_req and mem_ack, rd_ptr increments; the next entry is presented the following cycle, and mem_req stays high for back-to-back transfers.
- Latency: a store accepted at edge N reaches the memory interface, with mem_req high, from cycle N+1 when the FIFO was empty.

Count and pointer rules:
- Enqueue and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- full = (count = DEPTH); empty = (count = 0).

Load hazard:
- ld_stall = ld_check and (any valid entry has word address = MemAddr[31:2]).
- Byte enables are not considered: any overlap on the word stalls.
- An entry popped by mem_ack this cycle still counts toward the hazard this cycle.
- stall = full_stall or ld_stall.

Reset:
- count, wr_ptr and rd_ptr are set to 0, and all entry valid bits are cleared.
- mem_req = 0, stall = 0, empty = 1. mem_addr, mem_be and mem_wdata are 0.
- A reset during an outstanding request drops every pending entry. mem_req is low from the cycle after the reset edge, and a late mem_ack is ignored.

Decomposition:
- Opcode constants SW_OP, SH_OP and SB_OP join the shared MACRO.v include, alongside the existing load opcodes.
- Sub-module store_align holds the purely combinational decode (be, lane data, misalign).
- The FIFO, pointers and hazard compare stay in dm_store_buffer.

Test Plan:
1. sb with MemAddr=0x0000_1003, WD_in=0x1234_56AB, mem_ack held high -> next cycle mem_req=1, mem_addr=0x0000_1000, mem_be=1000, mem_wdata=0xABAB_ABAB; empty=1 two cycles after enqueue.
2. sh with MemAddr=0x0000_2002, WD_in=0xFFFF_8001 -> mem_be=1100, mem_wdata=0x8001_8001. Then sh with MemAddr=0x0000_2001 -> misalign=1, no enqueue, stall=0.
3. mem_ack held low; three consecutive sw to 0x10, 0x14, 0x18 with DEPTH=2 -> third cycle stall=1. Raise mem_ack for one cycle -> stall stays high that cycle; the store to 0x18 is accepted the cycle after; drain order is 0x10, 0x14, 0x18.
4. sw to 0x40 pending (mem_ack low), then lbu from 0x43 -> stall=1 until the cycle after the ack; lbu from 0x44 -> stall=0.
5. Back-to-back sw with mem_ack high every cycle -> mem_req stays high continuously; count never exceeds 1; no entry lost or duplicated.
6. Two entries pending, reset asserted for one cycle -> the cycle after: mem_req=0, empty=1, stall=0; a mem_ack pulse then has no effect.
